uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares the single uart_tx byte channel (base-station link) between several byte-stream requesters: command_translator drive bytes, ultrasonic/pitch telemetry, and LCD/debug echo.
- Arbitrates round-robin at packet boundaries and holds the grant for a whole packet.
- Bounds each grant with a burst limit and a stall timeout.
- Sits between the requesters and uart_tx, replacing the direct command_translator-to-uart_tx hookup.

Parameters:
- NREQ, 3: number of requesters; index 0 is drive commands.
- DATA_W, 8: byte width.
- MAX_BURST, 16: maximum bytes per grant before forced rotation.
- STALL_CYCLES, 1024: idle cycles tolerated mid-packet before the grant is revoked.

Ports:
- clk  in  1  system clock (clk_50 domain)
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  NREQ*DATA_W  packed bytes; requester i occupies [i*DATA_W +: DATA_W]
- req_last  in  NREQ  byte is the last of its packet
- req_ready  out  NREQ  byte accepted this cycle (one-hot or zero)
- tx_data  out  DATA_W  byte to uart_tx data_tx
- tx_valid  out  1  byte valid to uart_tx valid
- tx_ready  in  1  uart_tx tx_ready (idle/accept)
- grant  out  NREQ  one-hot current owner, zero when idle
- busy  out  1  a grant is held
- stall_err  out  1  one-cycle pulse when a grant is revoked by stall timeout

Behaviour:
- Reset (async assert, sync release) clears all registers:
  - Outputs: req_ready=0, tx_valid=0, tx_data=0, grant=0, busy=0, stall_err=0.
  - Internal: rr pointer=NREQ-1, burst count=0, stall count=0, state=IDLE.
- Output register: a single byte slot.
  - tx_valid=1 while full; transfer occurs when tx_valid && tx_ready.
  - Loading is permitted when the slot is empty or drains in the same cycle, so a packet streams back to back.
- State IDLE:
  - Any req_valid set: pick the first set bit searching from rr_ptr+1 upward, with wrap.
  - Register grant, rr_ptr = winner, go GRANTED.
  - The arbitration cycle accepts no data.
- State GRANTED, owner g:
  - req_ready[g] = req_valid[g] && slot loadable (combinational).
  - Accepted byte loads tx_data at the next edge; latency from acceptance to tx_valid is 1 cycle.
  - req_ready for non-owners is always 0.
  - Each accept increments burst count and clears stall count.
  - Each cycle with req_valid[g]=0 increments stall count.
- Transition to DRAIN happens on any of:
  - Accepted byte has req_last=1.
  - Burst count reaches MAX_BURST on this accept (forced rotation; the rest of the packet is served on a later grant).
  - Stall count reaches STALL_CYCLES-1 with no accept: pulse stall_err.
- State DRAIN:
  - Wait for the slot to empty (transfer).
  - Then clear grant and burst/stall counts, go IDLE.
  - busy=1 in GRANTED and DRAIN.
- Rules:
  - No requester is ever granted twice in a row while another req_valid is pending at arbitration.
  - A single requester re-wins after its own packet, costing one idle cycle between packets.
  - tx_ready low indefinitely: hold tx_valid/tx_data stable and never drop a byte; the stall counter does not count while the slot is full.
  - Requester drops valid mid-packet then reasserts before timeout: continue the same grant.
  - reset_n asserted mid-packet: the in-flight byte is discarded and tx_valid drops immediately.
- Widths:
  - Burst counter is clog2(MAX_BURST+1) bits.
  - Stall counter is clog2(STALL_CYCLES) bits and saturates.

Optional Feature:
- Macro UART_SCHED_PRIO_EN.
- Defined: requester 0 (drive commands) wins every IDLE arbitration it participates in; other requesters round-robin among themselves, and rr_ptr is not updated by a priority win. MAX_BURST still applies to requester 0.
- Undefined: pure round-robin across all NREQ.

Decomposition:
- Package uart_sched_pkg holds:
  - state enum {IDLE, GRANTED, DRAIN}
  - default NREQ/DATA_W/MAX_BURST/STALL_CYCLES localparams
  - a requester-index localparam for drive commands (0)
- One sub-module, rr_arbiter: parameterised NREQ; inputs req and pointer; outputs one-hot winner and its index. The priority override is applied in the top level.

Test Plan:
- Single packet: req 1 sends 0x41,0x42(last), tx_ready=1 → grant=3'b010 one cycle after valid; tx_data sequence 0x41,0x42 on consecutive cycles; busy drops after drain.
- Round-robin: all three present 2-byte packets continuously → tx order req0,req1,req2,req0; no interleaving within a packet.
- Backpressure: tx_ready=0 for 100 cycles mid-packet → tx_data held stable, req_ready=0, no stall_err, no byte loss.
- Burst limit: req2 sends 20 bytes, last on byte 20, with req0 pending → after 16 bytes grant moves to req0; the remaining 4 bytes follow later.
- Stall: req1 sends one non-last byte then deasserts for 1024 cycles → stall_err pulses once, grant clears, next requester served.
- With UART_SCHED_PRIO_EN: req0 and req1 both pending at every IDLE → req0 always wins; without the macro → strict alternation.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the uart_tx byte-channel scheduler.
// Optional build macro used by the scheduler: UART_SCHED_PRIO_EN.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        DRAIN   = 2'd2
    } sched_state_e;

    localparam int NREQ_DEF         = 3;
    localparam int DATA_W_DEF       = 8;
    localparam int MAX_BURST_DEF    = 16;
    localparam int STALL_CYCLES_DEF = 1024;

    // Requester slot wired to the command_translator drive-byte stream.
    localparam int DRIVE_IDX = 0;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first set request strictly after ptr, wrapping.
// Purely combinational; the caller owns and updates the pointer.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Offsets 1..NREQ so the previous winner is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                gnt[(int'(ptr) + k) % NREQ] = 1'b1;
                idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-granular round-robin scheduler sharing one uart_tx byte channel.
// Build macro UART_SCHED_PRIO_EN gives the drive-command requester strict priority.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NREQ         = NREQ_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_BURST    = MAX_BURST_DEF,
    parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     stall_err
);

    localparam int IW = idx_w(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STALL_CYCLES);

    sched_state_e      state_q,     state_d;
    logic [NREQ-1:0]   grant_q,     grant_d;
    logic [IW-1:0]     owner_q,     owner_d;
    logic [IW-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [BW-1:0]     burst_q,     burst_d;
    logic [SW-1:0]     stall_q,     stall_d;
    logic              tx_valid_q,  tx_valid_d;
    logic [DATA_W-1:0] tx_data_q,   tx_data_d;
    logic              busy_q,      busy_d;
    logic              stall_err_q, stall_err_d;

    logic              loadable;
    logic              accept;
    logic              owner_valid;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;

    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic [NREQ-1:0]   win_gnt;
    logic [IW-1:0]     win_idx;
    logic              upd_ptr;

    function automatic logic [SW-1:0] stall_sat_inc(input logic [SW-1:0] v);
        return (v == {SW{1'b1}}) ? v : v + 1'b1;
    endfunction

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        win_gnt = arb_gnt;
        win_idx = arb_idx;
        upd_ptr = 1'b1;
`ifdef UART_SCHED_PRIO_EN
        // A priority win leaves the pointer alone so the others keep their turn order.
        if (req_valid[DRIVE_IDX]) begin
            win_gnt            = '0;
            win_gnt[DRIVE_IDX] = 1'b1;
            win_idx            = IW'(DRIVE_IDX);
            upd_ptr            = 1'b0;
        end
`endif
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IW'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // The slot may refill in the same cycle it drains, so packets stream back to back.
    assign loadable  = !tx_valid_q || tx_ready;
    assign accept    = (state_q == GRANTED) && owner_valid && loadable;
    assign req_ready = accept ? grant_q : '0;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_d     = burst_q;
        stall_d     = stall_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        stall_err_d = 1'b0;

        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = owner_data;
        end

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = GRANTED;
                    grant_d = win_gnt;
                    owner_d = win_idx;
                    if (upd_ptr) begin
                        rr_ptr_d = win_idx;
                    end
                end
            end
            GRANTED: begin
                if (accept) begin
                    burst_d = burst_q + 1'b1;
                    stall_d = '0;
                    if (owner_last || (burst_d == BW'(MAX_BURST))) begin
                        state_d = DRAIN;
                    end
                end else if (!owner_valid && !tx_valid_q) begin
                    // Idle time only counts once the slot is empty; backpressure is not a stall.
                    if (stall_q == SW'(STALL_CYCLES - 1)) begin
                        state_d     = DRAIN;
                        stall_err_d = 1'b1;
                    end else begin
                        stall_d = stall_sat_inc(stall_q);
                    end
                end
            end
            DRAIN: begin
                if (!tx_valid_q || tx_ready) begin
                    state_d = IDLE;
                    grant_d = '0;
                    burst_d = '0;
                    stall_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                burst_d = '0;
                stall_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= IW'(NREQ - 1);
            burst_q     <= '0;
            stall_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_q     <= burst_d;
            stall_q     <= stall_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign stall_err = stall_err_q;

endmodule
